mem_port_arbiter: RTL and testbench

Two-master, single-slave arbiter for the core memory bus, sitting between `vproc_top` and `mmu`. It shares the single `mmu` memory port between the Vicuna/Ibex core (master 0) and the programming/debug loader (master 1). It carries one transaction at a time, registering request and response. Arbitration is round-robin, and `set_programming_mode` forces exclusive access for master 1. A per-transaction timeout protects against a hung slave.

---
 rtl/mem_port_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single mmu memory port between the core
// (master 0) and the programming/debug loader (master 1). Only one
// transaction is in flight at a time. Grants are round-robin, programming
// mode gives master 1 exclusive access, and a per-transaction timeout
// turns a hung slave into an error response.
module mem_port_arbiter #(
  parameter int MEM_W          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_programming_mode,

  input  logic                 m0_req_i,
  input  logic [31:0]          m0_addr_i,
  input  logic                 m0_we_i,
  input  logic [MEM_W/8-1:0]   m0_be_i,
  input  logic [MEM_W-1:0]     m0_wdata_i,
  output logic                 m0_rvalid_o,
  output logic                 m0_err_o,
  output logic [MEM_W-1:0]     m0_rdata_o,

  input  logic                 m1_req_i,
  input  logic [31:0]          m1_addr_i,
  input  logic                 m1_we_i,
  input  logic [MEM_W/8-1:0]   m1_be_i,
  input  logic [MEM_W-1:0]     m1_wdata_i,
  output logic                 m1_rvalid_o,
  output logic                 m1_err_o,
  output logic [MEM_W-1:0]     m1_rdata_o,

  output logic                 s_req_o,
  output logic [31:0]          s_addr_o,
  output logic                 s_we_o,
  output logic [MEM_W/8-1:0]   s_be_o,
  output logic [MEM_W-1:0]     s_wdata_o,
  input  logic                 s_rvalid_i,
  input  logic                 s_err_i,
  input  logic [MEM_W-1:0]     s_rdata_i,

  output logic                 busy_o,
  output logic                 owner_o
);

  localparam int BE_W  = MEM_W / 8;
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Counter value seen in the last allowed ISSUE cycle (counter starts at 0).
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic               r_last_grant;
  logic               r_owner;
  logic               r_busy;
  logic               r_s_req;
  logic [31:0]        r_s_addr;
  logic               r_s_we;
  logic [BE_W-1:0]    r_s_be;
  logic [MEM_W-1:0]   r_s_wdata;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_elig0;
  logic               w_elig1;
  logic               w_grant;
  logic               w_grant_idx;
  logic               w_done;
  logic               w_resp_err;
  logic [MEM_W-1:0]   w_resp_rdata;
  logic               w_cnt_inc;

  // Master 0 is locked out while programming mode is active.
  assign w_elig0 = m0_req_i & ~set_programming_mode;
  assign w_elig1 = m1_req_i;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: arbitration in IDLE, response/timeout detection in ISSUE.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_idx  = 1'b0;
    w_done       = 1'b0;
    w_resp_err   = 1'b0;
    w_resp_rdata = '0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_elig0 && w_elig1) begin
          w_grant     = 1'b1;
          w_grant_idx = ~r_last_grant;
        end else if (w_elig1) begin
          w_grant     = 1'b1;
          w_grant_idx = 1'b1;
        end else if (w_elig0) begin
          w_grant     = 1'b1;
          w_grant_idx = 1'b0;
        end
        if (w_grant) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A response arriving in the timeout cycle takes priority.
        if (s_rvalid_i) begin
          w_done       = 1'b1;
          w_resp_err   = s_err_i;
          w_resp_rdata = s_rdata_i;
          w_state_next = ST_RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST)) begin
          w_done       = 1'b1;
          w_resp_err   = 1'b1;
          w_resp_rdata = '0;
          w_state_next = ST_RESP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_RESP: begin
        // The owner still holds its old request here, so never arbitrate.
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Slave-side payload, ownership and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_busy       <= 1'b0;
      r_s_req      <= 1'b0;
      r_s_addr     <= '0;
      r_s_we       <= 1'b0;
      r_s_be       <= '0;
      r_s_wdata    <= '0;
      r_cnt        <= '0;
    end else begin
      r_busy <= (w_state_next != ST_IDLE);
      if (w_grant) begin
        r_s_req      <= 1'b1;
        r_owner      <= w_grant_idx;
        r_last_grant <= w_grant_idx;
        r_cnt        <= '0;
        r_s_addr     <= w_grant_idx ? m1_addr_i  : m0_addr_i;
        r_s_we       <= w_grant_idx ? m1_we_i    : m0_we_i;
        r_s_be       <= w_grant_idx ? m1_be_i    : m0_be_i;
        r_s_wdata    <= w_grant_idx ? m1_wdata_i : m0_wdata_i;
      end
      if (w_done) begin
        r_s_req <= 1'b0;
      end
      if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Per-master response registers; only the owner sees the rvalid pulse.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    localparam logic IDX = 1'(gi);
    logic             r_rvalid;
    logic             r_err;
    logic [MEM_W-1:0] r_rdata;

    // Capture the response for this master when it owns the finishing transaction.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rvalid <= 1'b0;
        r_err    <= 1'b0;
        r_rdata  <= '0;
      end else begin
        r_rvalid <= w_done && (r_owner == IDX);
        r_err    <= w_done && (r_owner == IDX) && w_resp_err;
        if (w_done && (r_owner == IDX)) begin
          r_rdata <= w_resp_rdata;
        end
      end
    end
  end

  assign m0_rvalid_o = g_resp[0].r_rvalid;
  assign m0_err_o    = g_resp[0].r_err;
  assign m0_rdata_o  = g_resp[0].r_rdata;
  assign m1_rvalid_o = g_resp[1].r_rvalid;
  assign m1_err_o    = g_resp[1].r_err;
  assign m1_rdata_o  = g_resp[1].r_rdata;

  assign s_req_o   = r_s_req;
  assign s_addr_o  = r_s_addr;
  assign s_we_o    = r_s_we;
  assign s_be_o    = r_s_be;
  assign s_wdata_o = r_s_wdata;
  assign busy_o    = r_busy;
  assign owner_o   = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT_CYCLES=4).
module tb_mem_port_arbiter;

  localparam int MEM_W = 32;
  localparam logic [31:0] M0_ADDR  = 32'h0000_0100;
  localparam logic [31:0] M1_ADDR  = 32'h0000_0200;
  localparam logic [31:0] M0_WDATA = 32'h1111_1111;
  localparam logic [31:0] M1_WDATA = 32'h2222_2222;

  logic        clk = 1'b0;
  logic        rst;
  logic        set_programming_mode;
  logic        m0_req_i, m1_req_i;
  logic [31:0] m0_addr_i, m1_addr_i;
  logic        m0_we_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic [31:0] m0_wdata_i, m1_wdata_i;
  logic        m0_rvalid_o, m1_rvalid_o;
  logic        m0_err_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_req_o;
  logic [31:0] s_addr_o;
  logic        s_we_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_wdata_o;
  logic        s_rvalid_i, s_err_i;
  logic [31:0] s_rdata_i;
  logic        busy_o, owner_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_W(MEM_W), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .set_programming_mode(set_programming_mode),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o),
    .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o),
    .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i), .s_err_i(s_err_i),
    .s_rdata_i(s_rdata_i), .busy_o(busy_o), .owner_o(owner_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    set_programming_mode = 1'b0;
    m0_req_i = 1'b0; m0_addr_i = M0_ADDR; m0_we_i = 1'b0; m0_be_i = 4'hF; m0_wdata_i = M0_WDATA;
    m1_req_i = 1'b0; m1_addr_i = M1_ADDR; m1_we_i = 1'b1; m1_be_i = 4'h3; m1_wdata_i = M1_WDATA;
    s_rvalid_i = 1'b0; s_err_i = 1'b0; s_rdata_i = 32'h0;
  endtask

  // Two reset cycles with random inputs, then every output must be zero.
  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_programming_mode = 1'($urandom);
      m0_req_i = 1'($urandom); m1_req_i = 1'($urandom);
      m0_addr_i = $urandom; m1_addr_i = $urandom;
      m0_we_i = 1'($urandom); m1_we_i = 1'($urandom);
      m0_be_i = 4'($urandom); m1_be_i = 4'($urandom);
      m0_wdata_i = $urandom; m1_wdata_i = $urandom;
      s_rvalid_i = 1'($urandom); s_err_i = 1'($urandom); s_rdata_i = $urandom;
      tick();
    end
    check_eq("rst_s_req", s_req_o, 0);
    check_eq("rst_s_addr", s_addr_o, 0);
    check_eq("rst_s_we", s_we_o, 0);
    check_eq("rst_s_be", s_be_o, 0);
    check_eq("rst_s_wdata", s_wdata_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_owner", owner_o, 0);
    check_eq("rst_rvalids", {m0_rvalid_o, m1_rvalid_o}, 0);
    check_eq("rst_errs", {m0_err_o, m1_err_o}, 0);
    check_eq("rst_m0_rdata", m0_rdata_o, 0);
    check_eq("rst_m1_rdata", m1_rdata_o, 0);
    clear_inputs();
    rst = 1'b0;
  endtask

  // One edge in IDLE with requests pending: expect a grant to own.
  task automatic expect_grant(input logic own);
    tick();
    check_eq("grant_s_req", s_req_o, 1);
    check_eq("grant_owner", owner_o, own);
    check_eq("grant_busy", busy_o, 1);
    check_eq("grant_s_addr", s_addr_o, own ? M1_ADDR : M0_ADDR);
    check_eq("grant_s_we", s_we_o, own ? 1 : 0);
    check_eq("grant_s_be", s_be_o, own ? 4'h3 : 4'hF);
    check_eq("grant_s_wdata", s_wdata_o, own ? M1_WDATA : M0_WDATA);
  endtask

  // Slave waits `waits` ISSUE cycles, then responds (or stays silent on a timeout).
  task automatic respond(input logic own, input int waits, input logic [31:0] rd,
                         input logic er, input logic timeout);
    logic [31:0] exp_rd;
    logic        exp_er;
    for (int i = 0; i < waits; i++) begin
      tick();
      check_eq("wait_s_req", s_req_o, 1);
      check_eq("wait_s_addr", s_addr_o, own ? M1_ADDR : M0_ADDR);
      check_eq("wait_rvalids", {m0_rvalid_o, m1_rvalid_o}, 0);
    end
    s_rvalid_i = ~timeout;
    s_rdata_i  = rd;
    s_err_i    = er;
    tick();
    s_rvalid_i = 1'b0;
    s_err_i    = 1'b0;
    exp_rd = timeout ? 32'h0 : rd;
    exp_er = timeout ? 1'b1 : er;
    check_eq("resp_rvalid_owner", own ? m1_rvalid_o : m0_rvalid_o, 1);
    check_eq("resp_rvalid_other", own ? m0_rvalid_o : m1_rvalid_o, 0);
    check_eq("resp_rdata", own ? m1_rdata_o : m0_rdata_o, exp_rd);
    check_eq("resp_err", own ? m1_err_o : m0_err_o, exp_er);
    check_eq("resp_s_req", s_req_o, 0);
    $display("[TB] txn owner=%0d waits=%0d timeout=%0d rdata=0x%08h err=%0d",
             own, waits, timeout, own ? m1_rdata_o : m0_rdata_o, own ? m1_err_o : m0_err_o);
    tick();
    check_eq("post_rvalids", {m0_rvalid_o, m1_rvalid_o}, 0);
    check_eq("post_busy", busy_o, 0);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;

    // Reset and single zero-wait read from master 0.
    do_reset();
    m0_req_i = 1'b1;
    expect_grant(1'b0);
    respond(1'b0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    m0_req_i = 1'b0;

    // Contention: alternating grants starting with master 0.
    do_reset();
    m0_req_i = 1'b1; m1_req_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_grant(1'(k % 2));
      respond(1'(k % 2), 0, 32'hA000_0000 + 32'(k), 1'b0, 1'b0);
    end
    m0_req_i = 1'b0; m1_req_i = 1'b0;

    // Programming mode with both requesting: only master 1 served.
    do_reset();
    set_programming_mode = 1'b1;
    m0_req_i = 1'b1; m1_req_i = 1'b1;
    expect_grant(1'b1);
    respond(1'b1, 0, 32'hB000_0001, 1'b0, 1'b0);
    expect_grant(1'b1);
    respond(1'b1, 1, 32'hB000_0002, 1'b0, 1'b0);
    m0_req_i = 1'b0; m1_req_i = 1'b0; set_programming_mode = 1'b0;

    // Mode raised while master 0 is in ISSUE: it completes, then starves.
    do_reset();
    m0_req_i = 1'b1;
    expect_grant(1'b0);
    set_programming_mode = 1'b1;
    m1_req_i = 1'b1;
    respond(1'b0, 1, 32'hC000_0001, 1'b0, 1'b0);
    expect_grant(1'b1);
    respond(1'b1, 0, 32'hC000_0002, 1'b0, 1'b0);
    m1_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("starve_busy", busy_o, 0);
      check_eq("starve_s_req", s_req_o, 0);
    end
    set_programming_mode = 1'b0;
    expect_grant(1'b0);
    respond(1'b0, 0, 32'hCAFE_F00D, 1'b0, 1'b0);

    // Timeout: 4 ISSUE cycles with no response, then err with rdata 0.
    expect_grant(1'b0);
    respond(1'b0, 3, 32'h5555_5555, 1'b0, 1'b1);
    // Response in the 4th ISSUE cycle wins over the timeout.
    expect_grant(1'b0);
    respond(1'b0, 3, 32'h1234_5678, 1'b0, 1'b0);
    // Slave error passes through.
    expect_grant(1'b0);
    respond(1'b0, 0, 32'h0000_0009, 1'b1, 1'b0);
    m0_req_i = 1'b0;

    // Reset during ISSUE: no rvalid, back to IDLE.
    tick();
    m0_req_i = 1'b1;
    expect_grant(1'b0);
    rst = 1'b1;
    s_rvalid_i = 1'b1;
    s_rdata_i = 32'hFFFF_FFFF;
    tick();
    check_eq("rst_issue_rvalid", m0_rvalid_o, 0);
    check_eq("rst_issue_busy", busy_o, 0);
    check_eq("rst_issue_s_req", s_req_o, 0);
    rst = 1'b0;
    s_rvalid_i = 1'b0;
    m0_req_i = 1'b0;
    tick();
    check_eq("after_rst_rvalid", m0_rvalid_o, 0);
    check_eq("after_rst_busy", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
